gen_rr_enc_top: RTL and testbench

GEN_RR_ENC_TOP -- requirements
Module: gen_rr_enc_top

---
 rtl/gen_rr_enc_top.sv | 103 ++++++++++
 tb/tb_gen_rr_enc_top.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_rr_enc_top.sv
// Round-robin / fixed-priority request encoder with a single valid/ready output register.
// Optional one-hot grant output gnt_vec is enabled by defining GEN_RR_ENC_GNT_VEC_EN.
module gen_rr_enc_top #(
  parameter int DAT_IN_W  = 8,
  parameter int PRIO_MODE = 1,
  localparam int DAT_OUT_W = $clog2(DAT_IN_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_in,
  output logic                 rdy_in,
  input  logic [DAT_IN_W-1:0]  dat_in,
  output logic                 vld_out,
  input  logic                 rdy_out,
  output logic [DAT_OUT_W-1:0] dat_out
`ifdef GEN_RR_ENC_GNT_VEC_EN
  ,
  output logic [DAT_IN_W-1:0]  gnt_vec
`endif
);

  logic                 vld_q, vld_d;
  logic [DAT_OUT_W-1:0] dat_q, dat_d;
  logic [DAT_OUT_W-1:0] ptr_q, ptr_d;
  logic [DAT_IN_W-1:0]  rot;
  logic                 found;
  logic [DAT_OUT_W-1:0] sel;
  logic                 in_xfer;
  logic                 out_xfer;

  // Modulo-DAT_IN_W add; both operands are below DAT_IN_W so one subtraction is exact.
  function automatic logic [DAT_OUT_W-1:0] wrap_add(input logic [DAT_OUT_W-1:0] base,
                                                    input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= DAT_IN_W) s = s - DAT_IN_W;
    return DAT_OUT_W'(s);
  endfunction

  assign rdy_in   = !vld_q || rdy_out;
  assign in_xfer  = vld_in && rdy_in;
  assign out_xfer = vld_q && rdy_out;
  assign vld_out  = vld_q;
  assign dat_out  = dat_q;

  // Rotate so bit 0 of rot is request[ptr]; the first set bit of rot is the grant.
  assign rot = DAT_IN_W'({dat_in, dat_in} >> ptr_q);

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < DAT_IN_W; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sel   = wrap_add(ptr_q, k);
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    ptr_d = ptr_q;
    if (in_xfer) begin
      vld_d = found;
      if (found) begin
        dat_d = sel;
        if (PRIO_MODE != 0) ptr_d = wrap_add(sel, 1);
      end
    end else if (out_xfer) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      ptr_q <= ptr_d;
    end
  end

`ifdef GEN_RR_ENC_GNT_VEC_EN
  logic [DAT_IN_W-1:0] gnt_q, gnt_d;

  always_comb begin
    gnt_d = '0;
    if (vld_d) gnt_d = {{(DAT_IN_W-1){1'b0}}, 1'b1} << dat_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gnt_q <= '0;
    else        gnt_q <= gnt_d;
  end

  assign gnt_vec = gnt_q;
`endif

endmodule

// File: tb/tb_gen_rr_enc_top.sv
// Bench for gen_rr_enc_top: directed vector table, corner sequences and a random run
// against a scan-and-modulo reference model on three configurations (8/RR, 8/fixed, 5/RR).
module tb_gen_rr_enc_top;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       vld_in, rdy_out;
  logic [7:0] dat_in;
  logic       rdy_in_m, vld_out_m, rdy_in_f, vld_out_f, rdy_in_n, vld_out_n;
  logic [2:0] dat_out_m, dat_out_f, dat_out_n;
  logic [7:0] gnt_m, gnt_f;
  logic [4:0] gnt_n;

  int n_vec = 0;
  int n_bad = 0;

  gen_rr_enc_top #(.DAT_IN_W(8), .PRIO_MODE(1)) u_m (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in_m), .dat_in(dat_in),
    .vld_out(vld_out_m), .rdy_out(rdy_out), .dat_out(dat_out_m)
`ifdef GEN_RR_ENC_GNT_VEC_EN
    , .gnt_vec(gnt_m)
`endif
  );

  gen_rr_enc_top #(.DAT_IN_W(8), .PRIO_MODE(0)) u_f (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in_f), .dat_in(dat_in),
    .vld_out(vld_out_f), .rdy_out(rdy_out), .dat_out(dat_out_f)
`ifdef GEN_RR_ENC_GNT_VEC_EN
    , .gnt_vec(gnt_f)
`endif
  );

  gen_rr_enc_top #(.DAT_IN_W(5), .PRIO_MODE(1)) u_n (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in_n), .dat_in(dat_in[4:0]),
    .vld_out(vld_out_n), .rdy_out(rdy_out), .dat_out(dat_out_n)
`ifdef GEN_RR_ENC_GNT_VEC_EN
    , .gnt_vec(gnt_n)
`endif
  );

`ifndef GEN_RR_ENC_GNT_VEC_EN
  assign gnt_m = '0;
  assign gnt_f = '0;
  assign gnt_n = '0;
`endif

  typedef struct {
    bit         vi;
    bit         ro;
    logic [7:0] d;
    bit         e_rdy;
    bit         e_vld;
    int         e_dat;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic v, input logic [2:0] dt,
                           input logic [7:0] g, input bit ev, input int ed);
    check({nm, " vld_out"}, 32'(v), 32'(ev));
    if (ev) check({nm, " dat_out"}, 32'(dt), ed);
`ifdef GEN_RR_ENC_GNT_VEC_EN
    check({nm, " gnt_vec"}, 32'(g), ev ? (32'd1 << ed) : 32'd0);
`else
    if (g !== 8'h00) check({nm, " gnt_vec tied"}, 32'(g), 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vld_in  = 1'b0;
    rdy_out = 1'b0;
    dat_in  = 8'h00;
    #2 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Reference: first set bit scanning ptr, ptr+1, ... modulo w; output slot emptied by a read.
  task automatic model(input int w, input bit rr, input bit vi, input bit ro, input logic [7:0] d,
                       inout int ptr, inout bit mv, inout int md);
    bit acc;
    int sel;
    acc = !mv || ro;
    sel = -1;
    if (vi && acc) begin
      for (int k = 0; k < w; k++) begin
        int p;
        p = (ptr + k) % w;
        if (sel < 0 && ((d >> p) & 8'd1) != 8'd0) sel = p;
      end
      if (sel >= 0) begin
        mv = 1'b1;
        md = sel;
        if (rr) ptr = (sel + 1) % w;
      end else begin
        mv = 1'b0;
      end
    end else if (mv && ro) begin
      mv = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   ptr_m, md_m, ptr_f, md_f, ptr_n, md_n, r;
    bit   mv_m, mv_f, mv_n;
    int   exp_m[3];
    int   exp_n[3];

    tbl[0]  = '{1, 1, 8'h81, 1, 1, 0};
    tbl[1]  = '{1, 1, 8'h81, 1, 1, 7};
    tbl[2]  = '{1, 1, 8'h81, 1, 1, 0};
    tbl[3]  = '{1, 1, 8'h00, 1, 0, 0};
    tbl[4]  = '{1, 1, 8'h06, 1, 1, 1};
    tbl[5]  = '{1, 1, 8'h08, 1, 1, 3};
    tbl[6]  = '{1, 0, 8'hFF, 0, 1, 3};
    tbl[7]  = '{1, 0, 8'hFF, 0, 1, 3};
    tbl[8]  = '{1, 0, 8'hFF, 0, 1, 3};
    tbl[9]  = '{1, 0, 8'hFF, 0, 1, 3};
    tbl[10] = '{1, 1, 8'hFF, 1, 1, 4};
    tbl[11] = '{0, 1, 8'hFF, 1, 0, 0};
    tbl[12] = '{0, 1, 8'hFF, 1, 0, 0};
    tbl[13] = '{1, 0, 8'h21, 1, 1, 5};
    tbl[14] = '{1, 0, 8'h01, 0, 1, 5};
    tbl[15] = '{1, 1, 8'h01, 1, 1, 0};

    rst_n   = 1'b1;
    vld_in  = 1'b0;
    rdy_out = 1'b0;
    dat_in  = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check("reset rdy_in", 32'(rdy_in_m), 32'd1);
    check("reset dat_out", 32'(dat_out_m), 32'd0);
    check_out("reset m", vld_out_m, dat_out_m, gnt_m, 1'b0, 0);
    vld_in = 1'b1;
    dat_in = 8'hFF;
    step();
    step();
    check("in-reset rdy_in", 32'(rdy_in_m), 32'd1);
    check_out("in-reset m", vld_out_m, dat_out_m, gnt_m, 1'b0, 0);
    vld_in = 1'b0;
    rst_n  = 1'b1;

    for (int i = 0; i < 16; i++) begin
      vld_in  = tbl[i].vi;
      rdy_out = tbl[i].ro;
      dat_in  = tbl[i].d;
      #1;
      check($sformatf("tbl[%0d] rdy_in", i), 32'(rdy_in_m), 32'(tbl[i].e_rdy));
      step();
      check_out($sformatf("tbl[%0d]", i), vld_out_m, dat_out_m, gnt_m, tbl[i].e_vld, tbl[i].e_dat);
    end

    // Load a grant at index 4 (ptr becomes 5), then reset between edges.
    vld_in  = 1'b1;
    rdy_out = 1'b1;
    dat_in  = 8'h10;
    step();
    check_out("pre-rst", vld_out_m, dat_out_m, gnt_m, 1'b1, 4);
    vld_in  = 1'b0;
    rdy_out = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst rdy_in", 32'(rdy_in_m), 32'd1);
    check("midrst dat_out", 32'(dat_out_m), 32'd0);
    check_out("midrst", vld_out_m, dat_out_m, gnt_m, 1'b0, 0);
    step();
    rst_n   = 1'b1;
    vld_in  = 1'b1;
    rdy_out = 1'b1;
    dat_in  = 8'h81;
    step();
    check_out("post-rst", vld_out_m, dat_out_m, gnt_m, 1'b1, 0);

    // 8'h81 three beats: round-robin alternates ends, fixed stays at 0.
    do_reset();
    exp_m = '{0, 7, 0};
    vld_in  = 1'b1;
    rdy_out = 1'b1;
    dat_in  = 8'h81;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("rr81[%0d]", i), vld_out_m, dat_out_m, gnt_m, 1'b1, exp_m[i]);
      check_out($sformatf("fix81[%0d]", i), vld_out_f, dat_out_f, gnt_f, 1'b1, 0);
    end

    // Non-power-of-2 width: 5'b10001 wraps 4 -> 0 exactly.
    do_reset();
    exp_n = '{0, 4, 0};
    vld_in  = 1'b1;
    rdy_out = 1'b1;
    dat_in  = 8'h11;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("w5[%0d]", i), vld_out_n, dat_out_n, {3'b000, gnt_n}, 1'b1, exp_n[i]);
      check_out($sformatf("fix11[%0d]", i), vld_out_f, dat_out_f, gnt_f, 1'b1, 0);
    end

    // Random traffic on all three configurations against the reference model.
    do_reset();
    ptr_m = 0; mv_m = 1'b0; md_m = 0;
    ptr_f = 0; mv_f = 1'b0; md_f = 0;
    ptr_n = 0; mv_n = 1'b0; md_n = 0;
    for (int c = 0; c < 600; c++) begin
      vld_in  = ($urandom_range(0, 3) != 0);
      rdy_out = ($urandom_range(0, 2) != 0);
      r = int'($urandom_range(0, 3));
      if (r == 0)      dat_in = 8'h00;
      else if (r == 1) dat_in = 8'h01 << $urandom_range(0, 7);
      else             dat_in = 8'($urandom);
      #1;
      check("rnd m rdy_in", 32'(rdy_in_m), 32'(!mv_m || rdy_out));
      check("rnd f rdy_in", 32'(rdy_in_f), 32'(!mv_f || rdy_out));
      check("rnd n rdy_in", 32'(rdy_in_n), 32'(!mv_n || rdy_out));
      model(8, 1'b1, vld_in, rdy_out, dat_in, ptr_m, mv_m, md_m);
      model(8, 1'b0, vld_in, rdy_out, dat_in, ptr_f, mv_f, md_f);
      model(5, 1'b1, vld_in, rdy_out, dat_in & 8'h1F, ptr_n, mv_n, md_n);
      step();
      check_out("rnd m", vld_out_m, dat_out_m, gnt_m, mv_m, md_m);
      check_out("rnd f", vld_out_f, dat_out_f, gnt_f, mv_f, md_f);
      check_out("rnd n", vld_out_n, dat_out_n, {3'b000, gnt_n}, mv_n, md_n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
